add_serial_param: RTL and testbench
===================================

Name: add_serial_param

Overview:
- Parametrised successor to the 8-bit bit-serial adder.
- Adds or subtracts two WIDTH-bit operands DIGIT bits per clock, LSB digit first.
- Reports carry-out and signed overflow; uses a level request/done handshake.
- Sits in the same datapath slot as the fixed adder, for narrow-area arithmetic units.

Parameters:
- WIDTH, 8, operand/result width; must be >= 2.
- DIGIT, 1, bits processed per cycle; must divide WIDTH; N = WIDTH/DIGIT digit cycles.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-low reset; sampled on the clk rising edge.
- en  in  1  request level; sampled only in IDLE to start; must stay high until done.
- a  in  WIDTH  operand A; captured at start.
- b  in  WIDTH  operand B; captured at start.
- sub  in  1  0 = a+b, 1 = a-b; captured at start.
- out  out  WIDTH  result register.
- cout  out  1  final carry; for sub, 1 = no borrow.
- ovf  out  1  signed two's-complement overflow of the final result.
- busy  out  1  high while in ADD.
- done  out  1  high while in DONE.

Behaviour:
- Reset (rst=0 at an edge): state=IDLE; out, cout, ovf, internal regs and count = 0. Reset applies from any state, including mid-ADD; the in-flight operation is discarded.
- States: IDLE, ADD, DONE (2-bit encoding, IDLE=0).
- IDLE & en=1 at edge 0:
  - a_reg<=a.
  - b_reg<=sub ? ~b : b.
  - carry<=sub.
  - out<=0, count<=0, cout<=0, ovf<=0.
  - Latch sign_a=a[WIDTH-1] and sign_b = MSB of the effective b.
  - Go to ADD.
- IDLE & en=0: hold.
- ADD, each edge:
  - DIGIT-bit ripple sum of a_reg[DIGIT-1:0], b_reg[DIGIT-1:0] and carry.
  - out<={sum_digit, out[WIDTH-1:DIGIT]}.
  - a_reg, b_reg shift right by DIGIT; carry<=digit carry-out; count<=count+1.
- On the ADD edge where count==N-1:
  - state<=DONE.
  - cout<=digit carry-out.
  - ovf<=(sign_a==sign_b) & (result MSB != sign_a).
- Latency: result valid and done=1 in the cycle after edge N, i.e. N+1 edges after en is sampled.
- During ADD, out shows a partial result and must not be consumed.
- ADD ignores en, a, b and sub. Dropping en mid-ADD does not abort; the operation completes, then DONE sees en=0 and returns to IDLE.
- DONE: out, cout and ovf are held. en=1 holds DONE; en=0 sends the block to IDLE on the next edge. There is no back-to-back restart without en going low for at least one cycle.
- Arithmetic is modulo 2^WIDTH; carry beyond WIDTH appears only on cout.
- Counter width = max(1, $clog2(N)). N=1 (DIGIT=WIDTH) is legal: a single ADD cycle.

Optional Feature:
- Macro ADD_SERIAL_SAT_EN.
- Defined: on the final ADD edge, if ovf is set, out<= sign_a ? {1'b1,{WIDTH-1{1'b0}}} : {1'b0,{WIDTH-1{1'b1}}} (signed saturation); ovf is still reported.
- Undefined: wrapped result, no saturation logic present.

Decomposition:
- Package add_serial_pkg:
  - state typedef and values IDLE=2'd0, ADD=2'd1, DONE=2'd2.
  - Mode constants MODE_ADD=1'b0, MODE_SUB=1'b1.
- Sub-module add_serial_digit:
  - Combinational, parameter DIGIT.
  - Inputs: a, b (DIGIT bits) and cin. Outputs: sum (DIGIT bits) and cout.
  - Instantiated once.
- FSM and registers live in the top module.

Test Plan:
- WIDTH=8, DIGIT=1, add a=8'h35, b=8'h4A -> out=8'h7F, cout=0, ovf=0; busy high for 8 cycles; done rises 9 edges after en is sampled.
- WIDTH=8, DIGIT=1, add a=8'h7F, b=8'h01:
  - Macro undefined -> out=8'h80, ovf=1, cout=0.
  - ADD_SERIAL_SAT_EN defined -> out=8'h7F, ovf=1.
- Sub a=8'h10, b=8'h20 -> out=8'hF0, cout=0, ovf=0. Sub a=8'h20, b=8'h10 -> out=8'h10, cout=1. Sub a=8'h80, b=8'h01 -> out=8'h7F, ovf=1 (saturated 8'h80 with macro).
- WIDTH=8, DIGIT=2, add a=8'hFF, b=8'h01 -> out=8'h00, cout=1; busy for exactly 4 cycles.
- Reset mid-op: drive rst=0 on the 3rd ADD cycle -> next edge out=0, state IDLE, busy=0. Release with en still high -> a fresh operation starts with newly captured a/b.
- Handshake: change a/b/sub during ADD -> no effect. Hold en in DONE for 5 cycles -> outputs stable, no restart. Drop en -> IDLE next edge, done=0.

Source files
------------

// File: rtl/add_serial_pkg.sv
// Shared types and constants for the parametrised bit-serial adder.
package add_serial_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    // Digit counter width; $clog2(1) is 0, so clamp to one bit.
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/add_serial_digit.sv
// One DIGIT-bit ripple-carry slice, reused every cycle by the serial adder.
module add_serial_digit #(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             cin,
    output logic [DIGIT-1:0] sum,
    output logic             cout
);

    logic [DIGIT:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < DIGIT; i++) begin : g_bit
        assign sum[i]  = a[i] ^ b[i] ^ c[i];
        assign c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout = c[DIGIT];

endmodule

// File: rtl/add_serial_param.sv
// Digit-serial add/subtract, LSB digit first, with carry-out and signed overflow.
// Define ADD_SERIAL_SAT_EN to saturate the result on signed overflow.
module add_serial_param
    import add_serial_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic [WIDTH-1:0] out,
    output logic             cout,
    output logic             ovf,
    output logic             busy,
    output logic             done
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = cnt_width(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_t           state, state_nx;
    logic [WIDTH-1:0] a_reg, b_reg;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] out_shift;
    logic [DIGIT-1:0] sum_d;
    logic             dig_c;
    logic             carry;
    logic             sign_a, sign_b;
    logic [CW-1:0]    count;
    logic             last;
    logic             ovf_nx;

    add_serial_digit #(.DIGIT(DIGIT)) u_digit (
        .a    (a_reg[DIGIT-1:0]),
        .b    (b_reg[DIGIT-1:0]),
        .cin  (carry),
        .sum  (sum_d),
        .cout (dig_c)
    );

    // Subtraction is a + ~b + 1: invert b at capture and seed the carry with sub.
    assign b_eff  = (sub == MODE_SUB) ? ~b : b;
    assign last   = (count == LAST);
    assign ovf_nx = (sign_a == sign_b) & (sum_d[DIGIT-1] != sign_a);
    assign busy   = (state == ADD);
    assign done   = (state == DONE);

    if (DIGIT == WIDTH) begin : g_one_digit
        assign out_shift = sum_d;
    end else begin : g_multi_digit
        assign out_shift = {sum_d, out[WIDTH-1:DIGIT]};
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (en)   state_nx = ADD;
            ADD:     if (last) state_nx = DONE;
            DONE:    if (!en)  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= IDLE;
            a_reg  <= '0;
            b_reg  <= '0;
            carry  <= 1'b0;
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            count  <= '0;
            out    <= '0;
            cout   <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (en) begin
                        a_reg  <= a;
                        b_reg  <= b_eff;
                        carry  <= sub;
                        sign_a <= a[WIDTH-1];
                        sign_b <= b_eff[WIDTH-1];
                        count  <= '0;
                        out    <= '0;
                        cout   <= 1'b0;
                        ovf    <= 1'b0;
                    end
                end
                ADD: begin
                    out   <= out_shift;
                    a_reg <= a_reg >> DIGIT;
                    b_reg <= b_reg >> DIGIT;
                    carry <= dig_c;
                    count <= count + 1'b1;
                    if (last) begin
                        cout <= dig_c;
                        ovf  <= ovf_nx;
`ifdef ADD_SERIAL_SAT_EN
                        if (ovf_nx)
                            out <= sign_a ? {1'b1, {(WIDTH-1){1'b0}}}
                                          : {1'b0, {(WIDTH-1){1'b1}}};
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_add_serial_param.sv
// Directed bench for add_serial_param: WIDTH=8 with DIGIT=1 and DIGIT=2 instances.
module tb_add_serial_param;

    logic       clk = 1'b0;
    logic       rst;
    logic       en1, en2;
    logic [7:0] a, b;
    logic       sub;
    logic [7:0] out1, out2;
    logic       cout1, cout2, ovf1, ovf2, busy1, busy2, done1, done2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    add_serial_param #(.WIDTH(8), .DIGIT(1)) u_d1 (
        .clk(clk), .rst(rst), .en(en1), .a(a), .b(b), .sub(sub),
        .out(out1), .cout(cout1), .ovf(ovf1), .busy(busy1), .done(done1)
    );

    add_serial_param #(.WIDTH(8), .DIGIT(2)) u_d2 (
        .clk(clk), .rst(rst), .en(en2), .a(a), .b(b), .sub(sub),
        .out(out2), .cout(cout2), .ovf(ovf2), .busy(busy2), .done(done2)
    );

    // Starts an operation at a negedge and waits (bounded) for done.
    task automatic do_op(input int sel, input logic [7:0] ta, input logic [7:0] tb_v,
                         input logic ts, output int edges, output int busy_cyc,
                         output bit timeout);
        @(negedge clk);
        a = ta; b = tb_v; sub = ts;
        if (sel == 1) en1 = 1'b1; else en2 = 1'b1;
        edges = 0; busy_cyc = 0; timeout = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            if ((sel == 1) ? busy1 : busy2) busy_cyc++;
            if ((sel == 1) ? done1 : done2) begin
                timeout = 1'b0;
                break;
            end
        end
    endtask

    task automatic drop_en();
        en1 = 1'b0; en2 = 1'b0;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0; en1 = 1'b0; en2 = 1'b0; a = 8'h00; b = 8'h00; sub = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (out1 !== 8'h00) begin errors++; $display("FAIL reset_out got %h exp 00", out1); end
        checks++; if ({cout1, ovf1, busy1, done1} !== 4'b0000) begin errors++; $display("FAIL reset_flags got %b exp 0000", {cout1, ovf1, busy1, done1}); end
        checks++; if ({out2, busy2, done2} !== 10'h000) begin errors++; $display("FAIL reset_d2 got %h exp 000", {out2, busy2, done2}); end
        rst = 1'b1;
    endtask

    task automatic test_add();
        int e, bc; bit to;
        do_op(1, 8'h35, 8'h4A, 1'b0, e, bc, to);
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL add_timeout got %0d exp 0", to); end
        checks++; if (out1 !== 8'h7F) begin errors++; $display("FAIL add_out got %h exp 7f", out1); end
        checks++; if ({cout1, ovf1} !== 2'b00) begin errors++; $display("FAIL add_flags got %b exp 00", {cout1, ovf1}); end
        checks++; if (e !== 9) begin errors++; $display("FAIL add_latency got %0d exp 9", e); end
        checks++; if (bc !== 8) begin errors++; $display("FAIL add_busy got %0d exp 8", bc); end
        drop_en();
        checks++; if (done1 !== 1'b0) begin errors++; $display("FAIL add_idle got %b exp 0", done1); end
    endtask

    task automatic test_overflow();
        int e, bc; bit to;
        logic [7:0] exp_o;
`ifdef ADD_SERIAL_SAT_EN
        exp_o = 8'h7F;
`else
        exp_o = 8'h80;
`endif
        do_op(1, 8'h7F, 8'h01, 1'b0, e, bc, to);
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL ovf_timeout got %0d exp 0", to); end
        checks++; if (out1 !== exp_o) begin errors++; $display("FAIL ovf_out got %h exp %h", out1, exp_o); end
        checks++; if ({cout1, ovf1} !== 2'b01) begin errors++; $display("FAIL ovf_flags got %b exp 01", {cout1, ovf1}); end
        drop_en();
    endtask

    task automatic test_sub();
        logic [7:0] va [3];
        logic [7:0] vb [3];
        logic [7:0] vo [3];
        logic [1:0] vf [3];   // {cout, ovf}
        int e, bc; bit to;
        va[0] = 8'h10; vb[0] = 8'h20; vo[0] = 8'hF0; vf[0] = 2'b00;
        va[1] = 8'h20; vb[1] = 8'h10; vo[1] = 8'h10; vf[1] = 2'b10;
        va[2] = 8'h80; vb[2] = 8'h01; vf[2] = 2'b11;
`ifdef ADD_SERIAL_SAT_EN
        vo[2] = 8'h80;
`else
        vo[2] = 8'h7F;
`endif
        for (int i = 0; i < 3; i++) begin
            do_op(1, va[i], vb[i], 1'b1, e, bc, to);
            checks++; if (to !== 1'b0) begin errors++; $display("FAIL sub%0d_timeout got %0d exp 0", i, to); end
            checks++; if (out1 !== vo[i]) begin errors++; $display("FAIL sub%0d_out got %h exp %h", i, out1, vo[i]); end
            checks++; if ({cout1, ovf1} !== vf[i]) begin errors++; $display("FAIL sub%0d_flags got %b exp %b", i, {cout1, ovf1}, vf[i]); end
            drop_en();
        end
    endtask

    task automatic test_digit2();
        int e, bc; bit to;
        do_op(2, 8'hFF, 8'h01, 1'b0, e, bc, to);
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL d2_timeout got %0d exp 0", to); end
        checks++; if (out2 !== 8'h00) begin errors++; $display("FAIL d2_out got %h exp 00", out2); end
        checks++; if ({cout2, ovf2} !== 2'b10) begin errors++; $display("FAIL d2_flags got %b exp 10", {cout2, ovf2}); end
        checks++; if (bc !== 4) begin errors++; $display("FAIL d2_busy got %0d exp 4", bc); end
        checks++; if (e !== 5) begin errors++; $display("FAIL d2_latency got %0d exp 5", e); end
        drop_en();
    endtask

    task automatic test_reset_mid();
        bit to;
        int e;
        @(negedge clk);
        a = 8'h35; b = 8'h4A; sub = 1'b0; en1 = 1'b1;
        repeat (3) @(posedge clk);   // capture edge plus two ADD edges
        @(negedge clk);
        checks++; if (busy1 !== 1'b1) begin errors++; $display("FAIL rmid_busy got %b exp 1", busy1); end
        rst = 1'b0; a = 8'h11; b = 8'h22;
        @(posedge clk);
        @(negedge clk);
        checks++; if ({out1, busy1, done1} !== 10'h000) begin errors++; $display("FAIL rmid_clear got %h exp 000", {out1, busy1, done1}); end
        rst = 1'b1;
        to = 1'b1; e = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            e++;
            @(negedge clk);
            if (done1) begin to = 1'b0; break; end
        end
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL rmid_timeout got %0d exp 0", to); end
        checks++; if (out1 !== 8'h33) begin errors++; $display("FAIL rmid_out got %h exp 33", out1); end
        checks++; if (e !== 9) begin errors++; $display("FAIL rmid_latency got %0d exp 9", e); end
        drop_en();
    endtask

    task automatic test_handshake();
        bit to;
        @(negedge clk);
        a = 8'h12; b = 8'h34; sub = 1'b0; en1 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        a = 8'hFF; b = 8'hFF; sub = 1'b1;
        to = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (done1) begin to = 1'b0; break; end
        end
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL hs_timeout got %0d exp 0", to); end
        checks++; if (out1 !== 8'h46) begin errors++; $display("FAIL hs_out got %h exp 46", out1); end
        checks++; if ({cout1, ovf1} !== 2'b00) begin errors++; $display("FAIL hs_flags got %b exp 00", {cout1, ovf1}); end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            @(negedge clk);
            checks++; if ({done1, busy1} !== 2'b10) begin errors++; $display("FAIL hs_hold%0d_state got %b exp 10", i, {done1, busy1}); end
            checks++; if (out1 !== 8'h46) begin errors++; $display("FAIL hs_hold%0d_out got %h exp 46", i, out1); end
        end
        drop_en();
        checks++; if ({done1, busy1} !== 2'b00) begin errors++; $display("FAIL hs_idle got %b exp 00", {done1, busy1}); end
        checks++; if (out1 !== 8'h46) begin errors++; $display("FAIL hs_idle_out got %h exp 46", out1); end
    endtask

    task automatic test_en_drop();
        bit to;
        @(negedge clk);
        a = 8'h01; b = 8'h02; sub = 1'b0; en1 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        en1 = 1'b0;
        to = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (done1) begin to = 1'b0; break; end
        end
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL drop_timeout got %0d exp 0", to); end
        checks++; if (out1 !== 8'h03) begin errors++; $display("FAIL drop_out got %h exp 03", out1); end
        @(posedge clk);
        @(negedge clk);
        checks++; if ({done1, busy1} !== 2'b00) begin errors++; $display("FAIL drop_idle got %b exp 00", {done1, busy1}); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_overflow();
        test_sub();
        test_digit2();
        test_reset_mid();
        test_handshake();
        test_en_drop();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
